decode_stage: RTL and testbench

Second pipeline stage, directly downstream of the fetch stage. Consumes fetched instruction words and PCs through a valid/ready handshake and decodes RV32I fields and immediates. Reads operands from an internal register file, blocks RAW/WAW hazards with a busy-bit scoreboard, and presents one registered decoded instruction per cycle to the execute stage. Also owns the register-file write port driven by writeback.

---
 rtl/riscv_pkg.sv | 91 +++++++++
 rtl/decode_stage_register_file.sv | 32 +++
 rtl/decode_stage.sv | 203 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: widths, opcodes, ALU ops, control bundle and immediate generation.
// Default widths come from RISCV_WORD_WIDTH / RISCV_ADDR_WIDTH when not supplied by the build.
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif

package riscv_pkg;

  localparam int WORD_W = `RISCV_WORD_WIDTH;
  localparam int ADDR_W = `RISCV_ADDR_WIDTH;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_COPY_B = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic       is_lui;
    logic       is_auipc;
    logic [2:0] funct3;
  } ctrl_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_t fmt);
    logic [31:0] imm;
    imm = 32'd0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'd0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

  // alt selects SUB/SRA; callers only raise it where the encoding allows it
  function automatic alu_op_t alu_from_funct(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    op = ALU_ADD;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// 32-entry integer register file: two combinational read ports, one write port, x0 hardwired to zero.
module register_file
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        i_raddr1,
  input  logic [4:0]        i_raddr2,
  output logic [WORD_W-1:0] o_rdata1,
  output logic [WORD_W-1:0] o_rdata2,
  input  logic              i_we,
  input  logic [4:0]        i_waddr,
  input  logic [WORD_W-1:0] i_wdata
);

  logic [WORD_W-1:0] r_regs [31:1];

  // Storage for x1..x31; writes aimed at x0 are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate decode, operand read, busy-bit scoreboard, registered output.
// Optional writeback bypass into hazard check and operand read: define DECODE_WB_BYPASS_EN.
module decode_stage
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] instr_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic              flush_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_rd_i,
  input  logic [WORD_W-1:0] wb_data_i,
  output logic              dec_valid_o,
  input  logic              dec_ready_i,
  output logic [ADDR_W-1:0] dec_pc_o,
  output logic [WORD_W-1:0] dec_rs1_data_o,
  output logic [WORD_W-1:0] dec_rs2_data_o,
  output logic [WORD_W-1:0] dec_imm_o,
  output logic [4:0]        dec_rd_o,
  output logic              dec_rd_we_o,
  output alu_op_t           dec_alu_op_o,
  output ctrl_t             dec_ctrl_o,
  output logic              dec_illegal_o
);

  logic [6:0]        w_opcode;
  logic [4:0]        w_rd, w_rs1, w_rs2;
  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;
  alu_op_t           w_alu_op;
  ctrl_t             w_ctrl;
  imm_fmt_t          w_imm_fmt;
  logic              w_uses_rs1, w_uses_rs2, w_writes_rd, w_illegal;
  logic              w_rd_we, w_chk_rs1, w_chk_rs2, w_hazard, w_load;
  logic [WORD_W-1:0] w_rf_rdata1, w_rf_rdata2, w_rs1_data, w_rs2_data, w_imm;
  logic [31:0]       w_busy_eff, w_set_mask, w_clr_mask, w_busy_nxt;

  logic              r_valid, r_rd_we, r_illegal;
  logic [ADDR_W-1:0] r_pc;
  logic [WORD_W-1:0] r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]        r_rd;
  alu_op_t           r_alu_op;
  ctrl_t             r_ctrl;
  logic [31:0]       r_busy;

  assign w_opcode = instr_i[6:0];
  assign w_rd     = instr_i[11:7];
  assign w_funct3 = instr_i[14:12];
  assign w_rs1    = instr_i[19:15];
  assign w_rs2    = instr_i[24:20];
  assign w_funct7 = instr_i[31:25];
  assign w_imm    = imm_gen(instr_i, w_imm_fmt);

  // Opcode/funct decode into control bundle, register usage and legality
  always_comb begin
    w_alu_op      = ALU_ADD;
    w_ctrl        = '0;
    w_ctrl.funct3 = w_funct3;
    w_imm_fmt     = IMM_NONE;
    w_uses_rs1    = 1'b0;
    w_uses_rs2    = 1'b0;
    w_writes_rd   = 1'b0;
    w_illegal     = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_ctrl.is_lui = 1'b1; w_imm_fmt = IMM_U; w_writes_rd = 1'b1; w_alu_op = ALU_COPY_B;
      end
      OPC_AUIPC: begin
        w_ctrl.is_auipc = 1'b1; w_imm_fmt = IMM_U; w_writes_rd = 1'b1;
      end
      OPC_JAL: begin
        w_ctrl.is_jal = 1'b1; w_imm_fmt = IMM_J; w_writes_rd = 1'b1;
      end
      OPC_JALR: begin
        w_ctrl.is_jalr = 1'b1; w_imm_fmt = IMM_I; w_writes_rd = 1'b1; w_uses_rs1 = 1'b1;
        w_illegal = (w_funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        w_ctrl.is_branch = 1'b1; w_imm_fmt = IMM_B; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
        w_alu_op  = ALU_SUB;
        w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
      end
      OPC_LOAD: begin
        w_ctrl.is_load = 1'b1; w_imm_fmt = IMM_I; w_writes_rd = 1'b1; w_uses_rs1 = 1'b1;
        w_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
      end
      OPC_STORE: begin
        w_ctrl.is_store = 1'b1; w_imm_fmt = IMM_S; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
        w_illegal = (w_funct3 > 3'b010);
      end
      OPC_OP_IMM: begin
        w_imm_fmt = IMM_I; w_writes_rd = 1'b1; w_uses_rs1 = 1'b1;
        w_alu_op  = alu_from_funct(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
        w_illegal = ((w_funct3 == 3'b001) && (w_funct7 != 7'd0)) ||
                    ((w_funct3 == 3'b101) && (w_funct7 != 7'd0) && (w_funct7 != 7'b0100000));
      end
      OPC_OP: begin
        w_writes_rd = 1'b1; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
        w_alu_op  = alu_from_funct(w_funct3, w_funct7[5]);
        w_illegal = (w_funct7 != 7'd0) &&
                    !((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_rd_we   = w_writes_rd & ~w_illegal & (w_rd != 5'd0);
  assign w_chk_rs1 = w_uses_rs1 & ~w_illegal & (w_rs1 != 5'd0);
  assign w_chk_rs2 = w_uses_rs2 & ~w_illegal & (w_rs2 != 5'd0);

  register_file u_register_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rf_rdata1),
    .o_rdata2 (w_rf_rdata2),
    .i_we     (wb_we_i),
    .i_waddr  (wb_rd_i),
    .i_wdata  (wb_data_i)
  );

`ifdef DECODE_WB_BYPASS_EN
  // A register being written back this cycle is already available to the consumer
  assign w_busy_eff = r_busy & ~(wb_we_i ? (32'd1 << wb_rd_i) : 32'd0);
  assign w_rs1_data = (wb_we_i && (wb_rd_i == w_rs1) && (w_rs1 != 5'd0)) ? wb_data_i : w_rf_rdata1;
  assign w_rs2_data = (wb_we_i && (wb_rd_i == w_rs2) && (w_rs2 != 5'd0)) ? wb_data_i : w_rf_rdata2;
`else
  assign w_busy_eff = r_busy;
  assign w_rs1_data = w_rf_rdata1;
  assign w_rs2_data = w_rf_rdata2;
`endif

  assign w_hazard = (w_chk_rs1 & w_busy_eff[w_rs1]) |
                    (w_chk_rs2 & w_busy_eff[w_rs2]) |
                    (w_rd_we   & w_busy_eff[w_rd]);

  assign instr_ready_o = rst_n & ~flush_i & ~w_hazard & (~r_valid | dec_ready_i);
  assign w_load        = instr_valid_i & instr_ready_o;

  // A flushed instruction never reaches writeback, so its busy bit is released here
  assign w_clr_mask = (wb_we_i ? (32'd1 << wb_rd_i) : 32'd0) |
                      ((flush_i & r_valid & r_rd_we) ? (32'd1 << r_rd) : 32'd0);
  assign w_set_mask = (w_load & w_rd_we) ? (32'd1 << w_rd) : 32'd0;
  assign w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;

  // Scoreboard busy bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Decode output register: flush, then load, then drain, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rd       <= 5'd0;
      r_rd_we    <= 1'b0;
      r_alu_op   <= ALU_ADD;
      r_ctrl     <= '0;
      r_illegal  <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid    <= 1'b1;
      r_pc       <= instr_addr_i;
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
      r_imm      <= w_imm;
      r_rd       <= w_rd;
      r_rd_we    <= w_rd_we;
      r_alu_op   <= w_alu_op;
      r_ctrl     <= w_ctrl;
      r_illegal  <= w_illegal;
    end else if (dec_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign dec_valid_o    = r_valid;
  assign dec_pc_o       = r_pc;
  assign dec_rs1_data_o = r_rs1_data;
  assign dec_rs2_data_o = r_rs2_data;
  assign dec_imm_o      = r_imm;
  assign dec_rd_o       = r_rd;
  assign dec_rd_we_o    = r_rd_we;
  assign dec_alu_op_o   = r_alu_op;
  assign dec_ctrl_o     = r_ctrl;
  assign dec_illegal_o  = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expectations follow DECODE_WB_BYPASS_EN if defined.
module tb_decode_stage;
  import riscv_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [WORD_W-1:0] instr_i = '0;
  logic [ADDR_W-1:0] instr_addr_i = '0;
  logic              instr_valid_i = 1'b0;
  logic              instr_ready_o;
  logic              flush_i = 1'b0;
  logic              wb_we_i = 1'b0;
  logic [4:0]        wb_rd_i = 5'd0;
  logic [WORD_W-1:0] wb_data_i = '0;
  logic              dec_valid_o;
  logic              dec_ready_i = 1'b1;
  logic [ADDR_W-1:0] dec_pc_o;
  logic [WORD_W-1:0] dec_rs1_data_o, dec_rs2_data_o, dec_imm_o;
  logic [4:0]        dec_rd_o;
  logic              dec_rd_we_o;
  alu_op_t           dec_alu_op_o;
  ctrl_t             dec_ctrl_o;
  logic              dec_illegal_o;

  int n_tests = 0;
  int n_fail  = 0;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .instr_addr_i(instr_addr_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .flush_i(flush_i),
    .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i), .dec_pc_o(dec_pc_o),
    .dec_rs1_data_o(dec_rs1_data_o), .dec_rs2_data_o(dec_rs2_data_o), .dec_imm_o(dec_imm_o),
    .dec_rd_o(dec_rd_o), .dec_rd_we_o(dec_rd_we_o), .dec_alu_op_o(dec_alu_op_o),
    .dec_ctrl_o(dec_ctrl_o), .dec_illegal_o(dec_illegal_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    instr_i       = instr;
    instr_addr_i  = pc[ADDR_W-1:0];
    instr_valid_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    offer(32'h00500093, 32'h0);
    #2;
    n_tests++; if (instr_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", instr_ready_o); end
    tick();
    n_tests++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dec_valid_o); end
    n_tests++; if ({dec_imm_o, dec_rd_o, dec_rd_we_o, dec_illegal_o} !== '0) begin n_fail++; $display("FAIL reset_fields: imm %h rd %0d we %b ill %b want all 0", dec_imm_o, dec_rd_o, dec_rd_we_o, dec_illegal_o); end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_raw_hazard();
    offer(32'h00500093, 32'h0);             // addi x1,x0,5
    #1;
    n_tests++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("FAIL addi_ready: got %b want 1", instr_ready_o); end
    tick();
    n_tests++; if ({dec_valid_o, dec_imm_o, dec_rd_o, dec_pc_o, dec_rd_we_o} !== {1'b1, 32'd5, 5'd1, 32'd0, 1'b1}) begin
      n_fail++; $display("FAIL addi_out: valid %b imm %h rd %0d pc %h we %b want 1/5/1/0/1", dec_valid_o, dec_imm_o, dec_rd_o, dec_pc_o, dec_rd_we_o); end
    n_tests++; if (dec_alu_op_o !== ALU_ADD) begin n_fail++; $display("FAIL addi_alu: got %0d want %0d", dec_alu_op_o, ALU_ADD); end
    offer(32'h00108133, 32'h4);             // add x2,x1,x1
    #1;
    n_tests++; if (instr_ready_o !== 1'b0) begin n_fail++; $display("FAIL raw_stall0: got %b want 0", instr_ready_o); end
    tick();
    n_tests++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL raw_drain: got %b want 0", dec_valid_o); end
    n_tests++; if (instr_ready_o !== 1'b0) begin n_fail++; $display("FAIL raw_stall1: got %b want 0", instr_ready_o); end
    tick();
    wb_we_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'd5;
    #1;
`ifdef DECODE_WB_BYPASS_EN
    n_tests++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("FAIL raw_wb_cycle_ready: got %b want 1", instr_ready_o); end
    tick();
    wb_we_i = 1'b0;
`else
    n_tests++; if (instr_ready_o !== 1'b0) begin n_fail++; $display("FAIL raw_wb_cycle_ready: got %b want 0", instr_ready_o); end
    tick();
    wb_we_i = 1'b0;
    #1;
    n_tests++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("FAIL raw_after_wb_ready: got %b want 1", instr_ready_o); end
    tick();
`endif
    n_tests++; if ({dec_valid_o, dec_pc_o, dec_rd_o, dec_rs1_data_o, dec_rs2_data_o} !== {1'b1, 32'd4, 5'd2, 32'd5, 32'd5}) begin
      n_fail++; $display("FAIL raw_out: valid %b pc %h rd %0d rs1 %h rs2 %h want 1/4/2/5/5", dec_valid_o, dec_pc_o, dec_rd_o, dec_rs1_data_o, dec_rs2_data_o); end
  endtask

  task automatic test_stall();
    dec_ready_i = 1'b0;
    offer(32'h00700193, 32'h8);             // addi x3,x0,7
    wb_we_i = 1'b1; wb_rd_i = 5'd2; wb_data_i = 32'd10;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (instr_ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b want 0", i, instr_ready_o); end
      n_tests++; if ({dec_valid_o, dec_pc_o, dec_rd_o, dec_rs1_data_o} !== {1'b1, 32'd4, 5'd2, 32'd5}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: valid %b pc %h rd %0d rs1 %h want 1/4/2/5", i, dec_valid_o, dec_pc_o, dec_rd_o, dec_rs1_data_o); end
      tick();
      wb_we_i = 1'b0;
    end
    dec_ready_i = 1'b1;
    #1;
    n_tests++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b want 1", instr_ready_o); end
    tick();
    n_tests++; if ({dec_valid_o, dec_pc_o, dec_rd_o, dec_imm_o} !== {1'b1, 32'd8, 5'd3, 32'd7}) begin
      n_fail++; $display("FAIL stall_release_out: valid %b pc %h rd %0d imm %h want 1/8/3/7", dec_valid_o, dec_pc_o, dec_rd_o, dec_imm_o); end
  endtask

  task automatic test_flush();
    dec_ready_i = 1'b0;
    flush_i     = 1'b1;
    offer(32'h00100213, 32'hC);             // addi x4,x0,1 offered during flush
    #1;
    n_tests++; if (instr_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", instr_ready_o); end
    tick();
    flush_i = 1'b0;
    n_tests++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", dec_valid_o); end
    offer(32'h003182B3, 32'h10);            // add x5,x3,x3
    #1;
    n_tests++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_busy3_cleared: ready %b want 1", instr_ready_o); end
    tick();
    n_tests++; if ({dec_valid_o, dec_pc_o, dec_rd_o, dec_rs1_data_o} !== {1'b1, 32'h10, 5'd5, 32'd0}) begin
      n_fail++; $display("FAIL flush_next_out: valid %b pc %h rd %0d rs1 %h want 1/10/5/0", dec_valid_o, dec_pc_o, dec_rd_o, dec_rs1_data_o); end
    dec_ready_i = 1'b1;
  endtask

  task automatic test_illegal();
    offer(32'h000000FF, 32'h14);            // opcode 0x7F, rd field = x1
    wb_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'd0;
    #1;
    n_tests++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("FAIL illegal_ready: got %b want 1", instr_ready_o); end
    tick();
    wb_we_i = 1'b0;
    n_tests++; if ({dec_valid_o, dec_illegal_o, dec_rd_we_o} !== 3'b110) begin
      n_fail++; $display("FAIL illegal_out: valid %b ill %b we %b want 1/1/0", dec_valid_o, dec_illegal_o, dec_rd_we_o); end
    offer(32'h00008313, 32'h18);            // addi x6,x1,0
    #1;
    n_tests++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("FAIL illegal_no_busy: ready %b want 1", instr_ready_o); end
    tick();
    n_tests++; if ({dec_illegal_o, dec_rd_o, dec_rs1_data_o} !== {1'b0, 5'd6, 32'd5}) begin
      n_fail++; $display("FAIL read_x1: ill %b rd %0d rs1 %h want 0/6/5", dec_illegal_o, dec_rd_o, dec_rs1_data_o); end
  endtask

  task automatic test_x0();
    instr_valid_i = 1'b0;
    wb_we_i = 1'b1; wb_rd_i = 5'd6; wb_data_i = 32'd5;
    tick();
    wb_rd_i = 5'd0; wb_data_i = 32'hDEADBEEF;
    offer(32'h00000433, 32'h1C);            // add x8,x0,x0 alongside the x0 write
    tick();
    wb_we_i = 1'b0;
    n_tests++; if ({dec_rs1_data_o, dec_rs2_data_o, dec_rd_o} !== {32'd0, 32'd0, 5'd8}) begin
      n_fail++; $display("FAIL x0_same_cycle: rs1 %h rs2 %h rd %0d want 0/0/8", dec_rs1_data_o, dec_rs2_data_o, dec_rd_o); end
    offer(32'h00000393, 32'h20);            // addi x7,x0,0
    tick();
    n_tests++; if ({dec_valid_o, dec_rs1_data_o, dec_rd_o} !== {1'b1, 32'd0, 5'd7}) begin
      n_fail++; $display("FAIL x0_read: valid %b rs1 %h rd %0d want 1/0/7", dec_valid_o, dec_rs1_data_o, dec_rd_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] instrs [5] = '{32'hFE20AE23, 32'hFE000CE3, 32'h123454B7, 32'hFFDFF56F, 32'hFFF00593};
    logic [31:0] imms   [5] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'hFFFFFFFC, 32'hFFFFFFFF};
    logic [6:0]  flags  [5] = '{7'b0100000, 7'b0010000, 7'b0000010, 7'b0001000, 7'b0000000};
    logic        wes    [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      offer(instrs[i], 32'h40 + 32'(i * 4));
      #1;
      n_tests++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, instr_ready_o); end
      tick();
      n_tests++; if (dec_imm_o !== imms[i]) begin n_fail++; $display("FAIL b2b_imm[%0d]: got %h want %h", i, dec_imm_o, imms[i]); end
      n_tests++; if ({dec_valid_o, dec_ctrl_o[9:3], dec_rd_we_o} !== {1'b1, flags[i], wes[i]}) begin
        n_fail++; $display("FAIL b2b_ctrl[%0d]: valid %b flags %b we %b want 1/%b/%b", i, dec_valid_o, dec_ctrl_o[9:3], dec_rd_we_o, flags[i], wes[i]); end
      if (i == 0) begin
        n_tests++; if ({dec_rs1_data_o, dec_rs2_data_o, dec_ctrl_o.funct3} !== {32'd5, 32'd10, 3'b010}) begin
          n_fail++; $display("FAIL sw_operands: rs1 %h rs2 %h f3 %b want 5/a/010", dec_rs1_data_o, dec_rs2_data_o, dec_ctrl_o.funct3); end
      end
      if (i == 2) begin
        n_tests++; if (dec_alu_op_o !== ALU_COPY_B) begin n_fail++; $display("FAIL lui_alu: got %0d want %0d", dec_alu_op_o, ALU_COPY_B); end
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    dec_ready_i = 1'b0;
    offer(32'h00048613, 32'h60);            // addi x12,x9,0 ; x9 busy from lui
    #1;
    n_tests++; if (instr_ready_o !== 1'b0) begin n_fail++; $display("FAIL busy9_stall: got %b want 0", instr_ready_o); end
    tick();
    rst_n = 1'b0;
    #1;
    n_tests++; if ({instr_ready_o, dec_valid_o} !== 2'b00) begin n_fail++; $display("FAIL midstall_reset: ready %b valid %b want 0/0", instr_ready_o, dec_valid_o); end
    tick();
    rst_n = 1'b1;
    #1;
    n_tests++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_clears_busy: ready %b want 1", instr_ready_o); end
    tick();
    n_tests++; if ({dec_valid_o, dec_pc_o, dec_rd_o} !== {1'b1, 32'h60, 5'd12}) begin
      n_fail++; $display("FAIL post_reset_load: valid %b pc %h rd %0d want 1/60/12", dec_valid_o, dec_pc_o, dec_rd_o); end
    instr_valid_i = 1'b0;
    dec_ready_i   = 1'b1;
  endtask

  initial begin
    test_reset();
    test_raw_hazard();
    test_stall();
    test_flush();
    test_illegal();
    test_x0();
    test_back_to_back();
    test_reset_mid_stall();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
